// File: rtl/id_pkg.sv
// Shared parameters and instruction field layout for the decode stage.
package id_pkg;

    localparam int NREG = 8;
    localparam int DW   = 8;
    localparam int IW   = 8;
    localparam int AW   = $clog2(NREG);

    localparam int JUMP_BIT = 7;
    localparam int OP_BIT   = 6;
    localparam int RS_MSB   = 5;
    localparam int RS_LSB   = 3;
    localparam int RT_MSB   = 2;
    localparam int RT_LSB   = 0;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/regfile_8x8.sv
// Register file: two async read ports with write-first bypass, one sync write port.
module regfile_8x8
    import id_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra_addr,
    output logic [DW-1:0] ra_data,
    input  logic [AW-1:0] rb_addr,
    output logic [DW-1:0] rb_data,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata
);

    logic [DW-1:0] mem_r [NREG];

    // Storage: reset loads each register with its own index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_r[i] <= DW'(i);
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read ports see a same-cycle write before it lands.
    always_comb begin
        ra_data = (we && (waddr == ra_addr)) ? wdata : mem_r[ra_addr];
        rb_data = (we && (waddr == rb_addr)) ? wdata : mem_r[rb_addr];
    end

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID capture, jump drop, scoreboard hazard check and
// valid/ready issue of ALU instructions to execute.
module id_stage
    import id_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] if_instr,
    input  logic          if_valid,
    output logic          if_stall,
    input  logic          ex_ready,
    output logic          ex_valid,
    output logic          ex_op,
    output logic [AW-1:0] ex_rd,
    output logic [DW-1:0] ex_a,
    output logic [DW-1:0] ex_b,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data
);

    logic            ifid_valid_r;
    logic [IW-1:0]   ifid_instr_r;
    logic [NREG-1:0] pend_r;
    logic            ex_valid_r;
    logic            ex_op_r;
    logic [AW-1:0]   ex_rd_r;
    logic [DW-1:0]   ex_a_r;
    logic [DW-1:0]   ex_b_r;

    logic            jump_s;
    logic            op_s;
    logic [AW-1:0]   rs_s;
    logic [AW-1:0]   rt_s;
    logic [NREG-1:0] wb_mask_s;
    logic [NREG-1:0] iss_mask_s;
    logic [NREG-1:0] pend_eff_s;
    logic            hazard_s;
    logic            out_free_s;
    logic            advance_s;
    logic            issue_s;
    logic [DW-1:0]   rs_data_s;
    logic [DW-1:0]   rt_data_s;

    regfile_8x8 u_rf (
        .clk     (clk),
        .rst     (rst),
        .ra_addr (rs_s),
        .ra_data (rs_data_s),
        .rb_addr (rt_s),
        .rb_data (rt_data_s),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data)
    );

    // Decode, hazard detection (writeback bypasses the pending bit) and handshake.
    always_comb begin
        jump_s     = ifid_instr_r[JUMP_BIT];
        op_s       = ifid_instr_r[OP_BIT];
        rs_s       = ifid_instr_r[RS_MSB:RS_LSB];
        rt_s       = ifid_instr_r[RT_MSB:RT_LSB];
        wb_mask_s  = wb_en ? ({{(NREG-1){1'b0}}, 1'b1} << wb_addr) : {NREG{1'b0}};
        pend_eff_s = pend_r & ~wb_mask_s;
        hazard_s   = !jump_s && (pend_eff_s[rs_s] || pend_eff_s[rt_s]);
        out_free_s = !ex_valid_r || ex_ready;
        advance_s  = ifid_valid_r && (jump_s || (!hazard_s && out_free_s));
        issue_s    = advance_s && !jump_s;
        iss_mask_s = issue_s ? ({{(NREG-1){1'b0}}, 1'b1} << rs_s) : {NREG{1'b0}};
        if_stall   = ifid_valid_r && !advance_s;
    end

    // IF/ID register: capture when fetch is not stalled, drain on advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_valid_r <= 1'b0;
            ifid_instr_r <= {IW{1'b0}};
        end else if (if_valid && !if_stall) begin
            ifid_valid_r <= 1'b1;
            ifid_instr_r <= if_instr;
        end else if (advance_s) begin
            ifid_valid_r <= 1'b0;
        end
    end

    // Scoreboard: writeback clears, issue sets, and the set wins a collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r <= {NREG{1'b0}};
        end else begin
            pend_r <= (pend_r & ~wb_mask_s) | iss_mask_s;
        end
    end

    // Execute-side output register; fields hold while stalled by ex_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_r <= 1'b0;
            ex_op_r    <= OP_ADD;
            ex_rd_r    <= {AW{1'b0}};
            ex_a_r     <= {DW{1'b0}};
            ex_b_r     <= {DW{1'b0}};
        end else if (issue_s) begin
            ex_valid_r <= 1'b1;
            ex_op_r    <= op_s;
            ex_rd_r    <= rs_s;
            ex_a_r     <= rs_data_s;
            ex_b_r     <= rt_data_s;
        end else if (ex_ready) begin
            ex_valid_r <= 1'b0;
        end
    end

    assign ex_valid = ex_valid_r;
    assign ex_op    = ex_op_r;
    assign ex_rd    = ex_rd_r;
    assign ex_a     = ex_a_r;
    assign ex_b     = ex_b_r;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the decode stage.
module tb_id_stage;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] if_instr = 8'd0;
    logic       if_valid = 1'b0;
    logic       if_stall;
    logic       ex_ready = 1'b1;
    logic       ex_valid;
    logic       ex_op;
    logic [2:0] ex_rd;
    logic [7:0] ex_a;
    logic [7:0] ex_b;
    logic       wb_en = 1'b0;
    logic [2:0] wb_addr = 3'd0;
    logic [7:0] wb_data = 8'd0;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    id_stage dut (
        .clk(clk), .rst(rst), .if_instr(if_instr), .if_valid(if_valid),
        .if_stall(if_stall), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_op(ex_op), .ex_rd(ex_rd), .ex_a(ex_a), .ex_b(ex_b),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    int   m_regs [8];
    bit   m_pend [8];
    bit   m_slot_v;
    int   m_slot_w;
    bit   m_out_v;
    int   m_out_op, m_out_rd, m_out_a, m_out_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_regs[i] = i;
            m_pend[i] = 1'b0;
        end
        m_slot_v = 1'b0; m_slot_w = 0;
        m_out_v = 1'b0; m_out_op = 0; m_out_rd = 0; m_out_a = 0; m_out_b = 0;
    endfunction

    function automatic bit reg_ready(input int r);
        return !m_pend[r] || (wb_en && int'(wb_addr) == r);
    endfunction

    function automatic int reg_value(input int r);
        return (wb_en && int'(wb_addr) == r) ? int'(wb_data) : m_regs[r];
    endfunction

    // Must fetch be held with the current model state and inputs?
    function automatic bit m_stall();
        int rs, rt;
        if (!m_slot_v || m_slot_w >= 128) return 1'b0;
        rs = (m_slot_w / 8) % 8;
        rt = m_slot_w % 8;
        return !(reg_ready(rs) && reg_ready(rt) && (!m_out_v || ex_ready));
    endfunction

    function automatic bit model_step();
        bit st, adv, iss;
        int rs, rt;
        st  = m_stall();
        adv = m_slot_v && !st;
        iss = adv && (m_slot_w < 128);
        rs  = (m_slot_w / 8) % 8;
        rt  = m_slot_w % 8;
        if (iss) begin
            m_out_v  = 1'b1;
            m_out_op = (m_slot_w / 64) % 2;
            m_out_rd = rs;
            m_out_a  = reg_value(rs);
            m_out_b  = reg_value(rt);
        end else if (ex_ready) begin
            m_out_v = 1'b0;
        end
        if (wb_en) begin
            m_regs[wb_addr] = wb_data;
            m_pend[wb_addr] = 1'b0;
        end
        if (iss) m_pend[rs] = 1'b1;
        if (if_valid && !st) begin
            m_slot_v = 1'b1;
            m_slot_w = if_instr;
        end else if (adv) begin
            m_slot_v = 1'b0;
        end
        return st;
    endfunction

    function automatic logic [7:0] m_pend_vec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // Compare process: outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("ex_valid", 32'(ex_valid), 32'(m_out_v));
            check("if_stall", 32'(if_stall), 32'(m_stall()));
            check("ex_op", 32'(ex_op), 32'(m_out_op));
            check("ex_rd", 32'(ex_rd), 32'(m_out_rd));
            check("ex_a", 32'(ex_a), 32'(m_out_a));
            check("ex_b", 32'(ex_b), 32'(m_out_b));
            check("pend", 32'(dut.pend_r), 32'(m_pend_vec()));
        end
    end

    task automatic drive(input bit iv, input logic [7:0] ins, input bit rdy,
                         input bit we, input logic [2:0] wa, input logic [7:0] wd);
        if_valid = iv; if_instr = ins; ex_ready = rdy;
        wb_en = we; wb_addr = wa; wb_data = wd;
        #2;
    endtask

    task automatic tick(output bit st);
        @(posedge clk);
        #1;
        st = model_step();
    endtask

    initial begin
        bit st;
        bit held;
        model_reset();
        @(posedge clk); #1;
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_if_stall", 32'(if_stall), 32'd0);
        check("rst_ex_a", 32'(ex_a), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // add r1,r3
        drive(1'b1, 8'h0B, 1'b1, 1'b0, 3'd0, 8'd0); tick(st);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'd0); tick(st);
        check("t1_valid", 32'(ex_valid), 32'd1);
        check("t1_op", 32'(ex_op), 32'd0);
        check("t1_rd", 32'(ex_rd), 32'd1);
        check("t1_a", 32'(ex_a), 32'd1);
        check("t1_b", 32'(ex_b), 32'd3);
        check("t1_pend", 32'(dut.pend_r), 32'h02);
        check("t1_model_b", 32'(m_out_b), 32'd3);
        drive(1'b0, 8'h00, 1'b1, 1'b1, 3'd1, 8'd1); tick(st);

        // add r1,r3 then dependent sub r1,r2, released by writeback r1=4
        drive(1'b1, 8'h0B, 1'b1, 1'b0, 3'd0, 8'd0); tick(st);
        drive(1'b1, 8'h4A, 1'b1, 1'b0, 3'd0, 8'd0); tick(st);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'd0);
        check("t2_stall", 32'(if_stall), 32'd1);
        tick(st);
        drive(1'b0, 8'h00, 1'b1, 1'b1, 3'd1, 8'd4);
        check("t2_stall_drop", 32'(if_stall), 32'd0);
        tick(st);
        check("t2_op", 32'(ex_op), 32'd1);
        check("t2_a", 32'(ex_a), 32'd4);
        check("t2_b", 32'(ex_b), 32'd2);
        check("t2_pend", 32'(dut.pend_r), 32'h02);
        check("t2_model_a", 32'(m_out_a), 32'd4);

        // jump is dropped
        drive(1'b1, 8'h85, 1'b1, 1'b0, 3'd0, 8'd0);
        check("t3_stall_a", 32'(if_stall), 32'd0);
        tick(st);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'd0);
        check("t3_stall_b", 32'(if_stall), 32'd0);
        tick(st);
        check("t3_valid", 32'(ex_valid), 32'd0);
        check("t3_pend", 32'(dut.pend_r), 32'h02);

        // back-pressure from execute
        drive(1'b0, 8'h00, 1'b0, 1'b1, 3'd1, 8'd1); tick(st);
        drive(1'b1, 8'h0B, 1'b0, 1'b0, 3'd0, 8'd0); tick(st);
        drive(1'b1, 8'h1A, 1'b0, 1'b0, 3'd0, 8'd0); tick(st);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'd0);
        check("t4_stall", 32'(if_stall), 32'd1);
        tick(st);
        check("t4_hold_rd", 32'(ex_rd), 32'd1);
        check("t4_hold_a", 32'(ex_a), 32'd1);
        check("t4_hold_b", 32'(ex_b), 32'd3);
        drive(1'b0, 8'h00, 1'b1, 1'b1, 3'd5, 8'hAA);
        check("t4_stall_drop", 32'(if_stall), 32'd0);
        tick(st);
        check("t4_rd", 32'(ex_rd), 32'd3);
        check("t4_a", 32'(ex_a), 32'd3);
        check("t4_b", 32'(ex_b), 32'd2);

        // asynchronous reset while busy
        drive(1'b1, 8'h0B, 1'b0, 1'b0, 3'd0, 8'd0); tick(st);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'd0);
        check("t5_pre_ifid", 32'(dut.ifid_valid_r), 32'd1);
        check("t5_pre_valid", 32'(ex_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("t5_valid", 32'(ex_valid), 32'd0);
        check("t5_stall", 32'(if_stall), 32'd0);
        check("t5_fields", 32'({ex_op, ex_rd, ex_a, ex_b}), 32'd0);
        check("t5_pend", 32'(dut.pend_r), 32'd0);
        check("t5_ifid", 32'(dut.ifid_valid_r), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check("t5_regfile", 32'(dut.u_rf.mem_r[i]), 32'(i));
        end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;

        // randomized traffic; fetch holds its word while stalled
        held = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            logic       iv;
            logic [7:0] ins;
            iv  = held ? if_valid : ($urandom_range(0, 99) < 70);
            ins = held ? if_instr : 8'($urandom);
            drive(iv, ins, ($urandom_range(0, 99) < 70),
                  ($urandom_range(0, 99) < 40), 3'($urandom_range(0, 7)),
                  8'($urandom));
            tick(st);
            held = st;
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage directly downstream of instruction fetch. Captures each 8-bit instruction word from fetch into an IF/ID register, discards jumps (already resolved by fetch), reads operands for ALU instructions from an 8x8 register file, and issues them to execute through a valid/ready handshake. Per-register pending bits hold back any instruction whose operands still await writeback, and the block stalls fetch while it is occupied.

## Interface
- NREG, 8, number of architectural registers
- DW, 8, register/data width
- IW, 8, instruction width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- if_instr  in  IW  instruction word from fetch
- if_valid  in  1  if_instr is valid this cycle
- if_stall  out  1  fetch must hold PC and instruction
- ex_ready  in  1  execute accepts the issued instruction
- ex_valid  out  1  ex_* outputs hold an instruction
- ex_op  out  1  0 = add, 1 = sub
- ex_rd  out  3  destination register
- ex_a  out  DW  operand rs
- ex_b  out  DW  operand rt
- wb_en  in  1  writeback strobe
- wb_addr  in  3  writeback register
- wb_data  in  DW  writeback value

## Operation
- Instruction format:
  - bit7 = 1: jump. Fetch handles it; this stage drops it.
  - bit7 = 0: ALU instruction. bit6 = op, [5:3] = rs = rd, [2:0] = rt.
- IF/ID register (ifid_valid, ifid_instr) loads when if_valid && !if_stall.
- hazard = ALU && (pend[rs] || pend[rt]), after bypass.
- Bypass: if wb_en && wb_addr == r, register r counts as not pending, and its operand read returns wb_data (write-first).
- out_free = !ex_valid || ex_ready.
- advance = ifid_valid && (jump || (!hazard && out_free)).
- if_stall = ifid_valid && !advance (combinational).
- On advance of an ALU instruction:
  - ex_* load the decoded fields and operands; ex_valid <= 1.
  - pend[rd] <= 1.
- On ex_ready && ex_valid with no new issue: ex_valid <= 0.
- On advance, ifid_valid <= 0, unless a new if_valid word is captured in the same cycle.
- wb_en writes wb_data to regfile[wb_addr] and clears pend[wb_addr].
- If an issue sets pend[r] and wb_en clears pend[r] in the same cycle, set wins.
- ex_* hold stable while ex_valid && !ex_ready.

## Timing
- Reset values:
  - regfile[i] = i
  - pend = 0, ifid_valid = 0
  - ex_valid = 0, ex_op = 0, ex_rd = 0, ex_a = 0, ex_b = 0
  - if_stall = 0
- Latency: instruction captured at edge N; earliest issue at edge N+1 (ex_valid high after N+1).
- Throughput: one instruction per cycle when there are no hazards and ex_ready = 1.
- A dependent back-to-back instruction stalls until the cycle in which wb_en targets the pending register. It issues at the end of that cycle with the bypassed value.
- Jump: consumed in one cycle after capture; no ex_valid pulse; pend unchanged.
- Reset asserted mid-operation clears the in-flight IF/ID and ex instructions and all pend bits, and reinitialises the register file, immediately (asynchronously).
- Writes to the same register from wb and issue in one cycle follow the rules above; no other write ports exist.

## Structure
- Package id_pkg holds:
  - NREG, DW, IW
  - field positions JUMP_BIT, OP_BIT, RS_MSB/LSB, RT_MSB/LSB
  - OP_ADD/OP_SUB constants
- Sub-module regfile_8x8:
  - two asynchronous read ports, one synchronous write port
  - asynchronous reset to regfile[i] = i
  - write-first bypass implemented inside the module
- Scoreboard (pend vector), IF/ID register, hazard/advance logic and output register stay in id_stage.

## Test plan
- Reset, then if_instr = 0x0B (add r1,r3) with if_valid for 1 cycle, ex_ready = 1:
  - ex_valid = 1 one cycle after capture
  - ex_op = 0, ex_rd = 1, ex_a = 1, ex_b = 3
  - pend[1] = 1
- 0x0B then 0x4A (sub r1,r2) back-to-back:
  - second instruction stalls (if_stall = 1)
  - wb_en = 1, wb_addr = 1, wb_data = 4 → same-cycle issue with ex_op = 1, ex_a = 4, ex_b = 2
  - if_stall drops in that cycle
- if_instr = 0x85 (jump):
  - captured and dropped; ex_valid stays 0; if_stall stays 0; pend unchanged
- ex_ready = 0 with 0x0B issued then 0x1A (add r3,r2) presented:
  - ex_* hold 1/3/1; if_stall = 1
  - ex_ready = 1 → 0x1A issues next edge with ex_a = 3, ex_b = 2
- Assert rst while ex_valid = 1, ifid_valid = 1, pend[1] = 1:
  - all outputs, pend and ifid_valid cleared immediately
  - regfile reads back i
